// File: rtl/serial_cmd_frame_decoder.sv
// rtl/serial_cmd_frame_decoder.sv - FF FF 00 LEN payload EE EE frame parser with valid/ready command output
// Optional inter-byte timeout enabled by defining SERIAL_DECODER_TIMEOUT_EN.
module serial_cmd_frame_decoder #(
    parameter int MAX_PAYLOAD = 8
`ifdef SERIAL_DECODER_TIMEOUT_EN
    , parameter int TIMEOUT_TICKS = 50000
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    input  logic                     rx_parity_err,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_len,
    output logic [MAX_PAYLOAD*8-1:0] cmd_payload,
    output logic                     err_valid,
    output logic [2:0]               err_code
);
    localparam int         PW      = MAX_PAYLOAD * 8;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    localparam logic [2:0] E_PARITY  = 3'd1;
    localparam logic [2:0] E_SPACE   = 3'd2;
    localparam logic [2:0] E_LEN     = 3'd3;
    localparam logic [2:0] E_EOF     = 3'd4;
    localparam logic [2:0] E_TIMEOUT = 3'd5;
    localparam logic [2:0] E_OVERRUN = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_EOF1, S_EOF2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_buf;
    logic [7:0]      r_len;
    logic [7:0]      r_idx;
    logic            r_cmd_valid;
    logic [7:0]      r_cmd_len;
    logic [PW-1:0]   r_cmd_payload;
    logic            r_err_valid;
    logic [2:0]      r_err_code;
    logic            w_err;
    logic [2:0]      w_code;
    logic            w_done;
    logic            w_timeout;
    logic            w_byte_ok;

    assign w_byte_ok = rx_valid && !rx_parity_err;

`ifdef SERIAL_DECODER_TIMEOUT_EN
    localparam int            TW   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT_TICKS - 1);
    logic [TW-1:0] r_tcnt;

    // Timeout is only evaluated on byte-free cycles, so a byte on the terminal count wins.
    assign w_timeout = !rx_valid && (r_state != S_IDLE) && (r_tcnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || rx_valid || w_timeout || r_state == S_IDLE) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_code      = 3'd0;
        w_done      = 1'b0;
        if (w_timeout) begin
            w_err  = 1'b1;
            w_code = E_TIMEOUT;
        end else if (rx_valid && rx_parity_err) begin
            if (r_state != S_IDLE) begin
                w_err  = 1'b1;
                w_code = E_PARITY;
            end
        end else if (rx_valid) begin
            case (r_state)
                S_IDLE:    if (rx_byte == 8'hFF) w_state_nxt = S_SOF2;
                S_SOF2:    w_state_nxt = (rx_byte == 8'hFF) ? S_SPACE : S_IDLE;
                S_SPACE: begin
                    if (rx_byte == 8'h00) w_state_nxt = S_LEN;
                    else begin w_err = 1'b1; w_code = E_SPACE; end
                end
                S_LEN: begin
                    if (rx_byte != 8'h00 && rx_byte <= MAX_LEN) w_state_nxt = S_PAYLOAD;
                    else begin w_err = 1'b1; w_code = E_LEN; end
                end
                S_PAYLOAD: if (r_idx + 8'd1 == r_len) w_state_nxt = S_EOF1;
                S_EOF1: begin
                    if (rx_byte == 8'hEE) w_state_nxt = S_EOF2;
                    else begin w_err = 1'b1; w_code = E_EOF; end
                end
                S_EOF2: begin
                    w_state_nxt = S_IDLE;
                    if (rx_byte != 8'hEE) begin
                        w_err = 1'b1; w_code = E_EOF;
                    end else if (r_cmd_valid && !cmd_ready) begin
                        w_err = 1'b1; w_code = E_OVERRUN;
                    end else begin
                        w_done = 1'b1;
                    end
                end
                default:   w_state_nxt = S_IDLE;
            endcase
        end
        if (w_err) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf         <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_len     <= '0;
            r_cmd_payload <= '0;
            r_err_valid   <= 1'b0;
            r_err_code    <= '0;
        end else begin
            r_err_valid <= w_err;
            if (w_err) r_err_code <= w_code;
            if (r_state == S_LEN && w_state_nxt == S_PAYLOAD) begin
                r_len <= rx_byte;
                r_idx <= '0;
                r_buf <= '0;
            end
            if (w_byte_ok && r_state == S_PAYLOAD) begin
                for (int i = 0; i < MAX_PAYLOAD; i++) begin
                    if (r_idx == 8'(i)) r_buf[i*8 +: 8] <= rx_byte;
                end
                r_idx <= r_idx + 8'd1;
            end
            if (w_err) r_buf <= '0;
            // A completion in the same cycle as a handshake replaces the accepted command.
            if (w_done) begin
                r_cmd_valid   <= 1'b1;
                r_cmd_len     <= r_len;
                r_cmd_payload <= r_buf;
            end else if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_len     = r_cmd_len;
    assign cmd_payload = r_cmd_payload;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;
endmodule

// File: tb/tb_serial_cmd_frame_decoder.sv
// tb/tb_serial_cmd_frame_decoder.sv - table-driven and scoreboard bench for serial_cmd_frame_decoder
module tb_serial_cmd_frame_decoder;
    localparam int MP = 8;
    localparam int TT = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_parity_err;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_len;
    logic [MP*8-1:0] cmd_payload;
    logic          err_valid;
    logic [2:0]    err_code;

`ifdef SERIAL_DECODER_TIMEOUT_EN
    serial_cmd_frame_decoder #(.MAX_PAYLOAD(MP), .TIMEOUT_TICKS(TT)) dut (
`else
    serial_cmd_frame_decoder #(.MAX_PAYLOAD(MP)) dut (
`endif
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_payload(cmd_payload), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  len;
        logic [63:0] pay;
    } cmd_t;

    typedef struct packed {
        logic [4:0]   n;
        logic [127:0] b;
        logic [4:0]   perr;
        logic [1:0]   kind;
        logic [2:0]   code;
        logic [7:0]   len;
        logic [63:0]  pay;
    } vec_t;

    cmd_t       exp_cmd[$];
    logic [2:0] exp_err[$];
    int         n_checks = 0;
    int         n_errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe);
        @(negedge clk); #1;
        rx_byte = b; rx_valid = 1'b1; rx_parity_err = pe;
        @(negedge clk); #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] len, input logic [63:0] pay);
        cmd_t c;
        c.len = len; c.pay = pay;
        exp_cmd.push_back(c);
    endtask

    task automatic good_frame(input logic [7:0] p);
        push_cmd(8'd1, {56'd0, p});
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(p, 1'b0);
        send_byte(8'hEE, 1'b0); send_byte(8'hEE, 1'b0);
    endtask

    // Scoreboard monitor: samples mid-cycle, after inputs for the next edge are settled.
    always begin
        @(negedge clk); #2;
        if (!rst) begin
            if (err_valid) begin
                if (exp_err.size() == 0) begin
                    n_checks++; n_errs++;
                    $display("FAIL unexpected_err: got code %0d expected no error", err_code);
                end else begin
                    chk("err_code", 64'(err_code), 64'(exp_err.pop_front()));
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    n_checks++; n_errs++;
                    $display("FAIL unexpected_cmd: got len %0d payload %0h expected none", cmd_len, cmd_payload);
                end else begin
                    cmd_t e;
                    e = exp_cmd.pop_front();
                    chk("cmd_len", 64'(cmd_len), 64'(e.len));
                    chk("cmd_payload", cmd_payload, e.pay);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{n:5'd8,  b:128'hFFFF0002_0203EEEE,                perr:5'd31, kind:2'd1, code:3'd0, len:8'd2, pay:64'h0302};
        vecs[1]  = '{n:5'd11, b:128'h1234FF12_FFFF0001_05EEEE,         perr:5'd31, kind:2'd1, code:3'd0, len:8'd1, pay:64'h05};
        vecs[2]  = '{n:5'd3,  b:128'hFFFF01,                           perr:5'd31, kind:2'd2, code:3'd2, len:8'd0, pay:64'h0};
        vecs[3]  = '{n:5'd4,  b:128'hFFFF0009,                         perr:5'd31, kind:2'd2, code:3'd3, len:8'd0, pay:64'h0};
        vecs[4]  = '{n:5'd7,  b:128'hFFFF0001_AAFFEE,                  perr:5'd31, kind:2'd2, code:3'd4, len:8'd0, pay:64'h0};
        vecs[5]  = '{n:5'd9,  b:128'hFFFF0003_102030EEEE,              perr:5'd5,  kind:2'd2, code:3'd1, len:8'd0, pay:64'h0};
        vecs[6]  = '{n:5'd1,  b:128'hFF,                               perr:5'd0,  kind:2'd0, code:3'd0, len:8'd0, pay:64'h0};
        vecs[7]  = '{n:5'd14, b:128'hFFFF0008_01020304_05060708_EEEE,  perr:5'd31, kind:2'd1, code:3'd0, len:8'd8, pay:64'h0807060504030201};
        vecs[8]  = '{n:5'd4,  b:128'hFFFF0000,                         perr:5'd31, kind:2'd2, code:3'd3, len:8'd0, pay:64'h0};
        vecs[9]  = '{n:5'd2,  b:128'hFFFF,                             perr:5'd1,  kind:2'd2, code:3'd1, len:8'd0, pay:64'h0};
        vecs[10] = '{n:5'd7,  b:128'hFFFF0001_07EE00,                  perr:5'd31, kind:2'd2, code:3'd4, len:8'd0, pay:64'h0};

        rst = 1'b1; rx_byte = 8'hFF; rx_valid = 1'b1; rx_parity_err = 1'b0; cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("reset_err_valid", 64'(err_valid), 64'd0);
        chk("reset_err_code", 64'(err_code), 64'd0);
        chk("reset_cmd_payload", cmd_payload, 64'd0);
        rst = 1'b0; rx_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Completion latency: cmd_valid appears right after the final EE and drops after handshake.
        push_cmd(8'd1, 64'h5A);
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h5A, 1'b0); send_byte(8'hEE, 1'b0);
        chk("pre_eof_cmd_valid", 64'(cmd_valid), 64'd0);
        send_byte(8'hEE, 1'b0);
        chk("latency_cmd_valid", 64'(cmd_valid), 64'd1);
        @(negedge clk); #1;
        chk("post_hs_cmd_valid", 64'(cmd_valid), 64'd0);

        for (int i = 0; i < 11; i++) begin
            int nb;
            nb = int'(vecs[i].n);
            if (vecs[i].kind == 2'd1) push_cmd(vecs[i].len, vecs[i].pay);
            if (vecs[i].kind == 2'd2) exp_err.push_back(vecs[i].code);
            for (int j = 0; j < nb; j++) begin
                send_byte(vecs[i].b[(nb-1-j)*8 +: 8], (int'(vecs[i].perr) == j));
            end
            repeat (3) @(negedge clk);
            if (vecs[i].kind == 2'd2) begin
                good_frame(8'(8'h80 + i));
                repeat (3) @(negedge clk);
            end
        end
        chk("err_code_held", 64'(err_code), 64'd4);

        // Reset mid-frame discards the partial frame.
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0); send_byte(8'hAA, 1'b0);
        @(negedge clk); #1; rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("midreset_err_code", 64'(err_code), 64'd0);
        rst = 1'b0;
        send_byte(8'h55, 1'b0); send_byte(8'hEE, 1'b0); send_byte(8'hEE, 1'b0);
        repeat (3) @(negedge clk);
        good_frame(8'h66);
        repeat (3) @(negedge clk);

        // Overrun while a command is pending, then a load coinciding with the handshake.
        cmd_ready = 1'b0;
        push_cmd(8'd1, 64'h11);
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'hEE, 1'b0); send_byte(8'hEE, 1'b0);
        exp_err.push_back(3'd6);
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'hEE, 1'b0); send_byte(8'hEE, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("overrun_keeps_valid", 64'(cmd_valid), 64'd1);
        chk("overrun_keeps_payload", cmd_payload, 64'h11);
        push_cmd(8'd1, 64'h33);
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'hEE, 1'b0);
        @(negedge clk); #1;
        rx_byte = 8'hEE; rx_valid = 1'b1; cmd_ready = 1'b1;
        @(negedge clk); #1;
        rx_valid = 1'b0;
        chk("handshake_load_payload", cmd_payload, 64'h33);
        repeat (3) @(negedge clk);

`ifdef SERIAL_DECODER_TIMEOUT_EN
        begin
            int found;
            found = 0;
            exp_err.push_back(3'd5);
            send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
            for (int k = 1; k <= TT + 10 && found == 0; k++) begin
                @(posedge clk); #1;
                if (err_valid) found = k;
            end
            chk("timeout_latency", 64'(found), 64'(TT));
            repeat (3) @(negedge clk);
            push_cmd(8'd1, 64'h44);
            send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
            repeat (TT - 2) @(negedge clk);
            send_byte(8'h01, 1'b0);
            send_byte(8'h44, 1'b0); send_byte(8'hEE, 1'b0); send_byte(8'hEE, 1'b0);
            repeat (3) @(negedge clk);
        end
`else
        begin
            int pulses;
            pulses = 0;
            send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
            for (int k = 0; k < 2000; k++) begin
                @(posedge clk); #1;
                if (err_valid) pulses++;
            end
            chk("no_timeout_pulses", 64'(pulses), 64'd0);
            push_cmd(8'd1, 64'h55);
            send_byte(8'h01, 1'b0); send_byte(8'h55, 1'b0);
            send_byte(8'hEE, 1'b0); send_byte(8'hEE, 1'b0);
            repeat (3) @(negedge clk);
        end
`endif

        repeat (10) @(negedge clk);
        chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        chk("err_queue_drained", 64'(exp_err.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
